// File: rtl/iter_fft_ctrl_pkg.sv
// Shared definitions for the iterative FFT sequencing controller:
// FSM state encodings and the butterfly slot length.
package iter_fft_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRIME = 3'd1,
    ST_RUN   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // The iterative butterfly needs exactly four cycles per pair.
  localparam int BFLY_PERIOD_DEF = 4;

endpackage

// File: rtl/fft_bfly_addr_gen.sv
// Combinational radix-2 DIT butterfly indexer: (stage, j) -> operand
// addresses and twiddle ROM address.
module fft_bfly_addr_gen #(
  parameter  int N_LOG2 = 8,
  localparam int SW     = $clog2(N_LOG2)
) (
  input  logic [SW-1:0]     i_stage,
  input  logic [N_LOG2-2:0] i_j,
  output logic [N_LOG2-1:0] o_addr_a,
  output logic [N_LOG2-1:0] o_addr_b,
  output logic [N_LOG2-2:0] o_tw
);

  logic [N_LOG2-1:0] w_j;
  logic [N_LOG2-1:0] w_h;
  logic [N_LOG2-1:0] w_p;
  logic [N_LOG2-1:0] w_g;
  logic [SW-1:0]     w_tsh;

  always_comb begin
    w_j      = {1'b0, i_j};
    w_h      = N_LOG2'(1) << i_stage;
    w_p      = w_j & (w_h - N_LOG2'(1));
    w_g      = w_j >> i_stage;
    // Shift in two steps so stage+1 never has to fit in the stage width.
    o_addr_a = ((w_g << i_stage) << 1) | w_p;
    o_addr_b = o_addr_a | w_h;
    w_tsh    = SW'(N_LOG2 - 1) - i_stage;
    o_tw     = (N_LOG2-1)'(w_p << w_tsh);
  end

endmodule

// File: rtl/iter_fft_ctrl.sv
// Stage/butterfly sequencer for the in-place iterative FFT: drives RAM
// read/write ports, twiddle address and the 4-cycle butterfly strobe.
module iter_fft_ctrl
  import iter_fft_ctrl_pkg::*;
#(
  parameter  int N_LOG2      = 8,
  parameter  int BFLY_PERIOD = BFLY_PERIOD_DEF,
  localparam int SW          = $clog2(N_LOG2),
  localparam int JW          = N_LOG2 - 1,
  localparam int PW          = $clog2(BFLY_PERIOD)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [SW-1:0]     stage,
  output logic              rd_en,
  output logic [N_LOG2-1:0] rd_addr_a,
  output logic [N_LOG2-1:0] rd_addr_b,
  output logic [N_LOG2-2:0] tw_addr,
  output logic              bfly_strb,
  output logic              wr_en,
  output logic [N_LOG2-1:0] wr_addr_a,
  output logic [N_LOG2-1:0] wr_addr_b
);

  localparam logic [JW-1:0] J_LAST  = '1;
  localparam logic [PW-1:0] PH_LAST = PW'(BFLY_PERIOD - 1);
  localparam logic [SW-1:0] ST_LAST = SW'(N_LOG2 - 1);

  state_t            r_state, w_nxt;
  logic [PW-1:0]     r_phase;
  logic [JW-1:0]     r_j;
  logic [SW-1:0]     r_stage;
  logic [N_LOG2-1:0] r_ra, r_rb;
  logic [N_LOG2-1:0] r_wa, r_wb;

  logic              w_last_ph;
  logic [JW-1:0]     w_j_rd;
  logic [N_LOG2-1:0] w_rd_a, w_rd_b;
  logic [N_LOG2-2:0] w_rd_tw;

  assign w_last_ph = (r_phase == PH_LAST);
  // In RUN the read issued at phase 3 prefetches the next pair.
  assign w_j_rd    = (r_state == ST_RUN) ? r_j + JW'(1) : r_j;
  assign stage     = r_stage;

  fft_bfly_addr_gen #(.N_LOG2(N_LOG2)) u_addr_gen (
    .i_stage  (r_stage),
    .i_j      (w_j_rd),
    .o_addr_a (w_rd_a),
    .o_addr_b (w_rd_b),
    .o_tw     (w_rd_tw)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_nxt = ST_PRIME;
      ST_PRIME: w_nxt = ST_RUN;
      ST_RUN:   if (w_last_ph && r_j == J_LAST) w_nxt = ST_FLUSH;
      ST_FLUSH: if (r_phase == PW'(1)) w_nxt = (r_stage != ST_LAST) ? ST_PRIME : ST_DONE;
      ST_DONE:  w_nxt = ST_IDLE;
      default:  w_nxt = ST_IDLE;
    endcase
  end

  // r_ra/r_rb hold the pair last read; at phase 3 they shift into the write
  // delay registers just as the next pair's addresses replace them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase <= '0;
      r_j     <= '0;
      r_stage <= '0;
      r_ra    <= '0;
      r_rb    <= '0;
      r_wa    <= '0;
      r_wb    <= '0;
    end else begin
      if (rd_en) begin
        r_ra <= w_rd_a;
        r_rb <= w_rd_b;
      end
      case (r_state)
        ST_IDLE: if (start) begin
          r_stage <= '0;
          r_j     <= '0;
          r_phase <= '0;
        end
        ST_PRIME: r_phase <= '0;
        ST_RUN: begin
          if (w_last_ph) begin
            r_phase <= '0;
            r_wa    <= r_ra;
            r_wb    <= r_rb;
            if (r_j != J_LAST) r_j <= r_j + JW'(1);
          end else begin
            r_phase <= r_phase + PW'(1);
          end
        end
        ST_FLUSH: begin
          if (r_phase == PW'(0)) begin
            r_phase <= PW'(1);
          end else begin
            r_phase <= '0;
            r_j     <= '0;
            if (r_stage != ST_LAST) r_stage <= r_stage + SW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    rd_en     = 1'b0;
    bfly_strb = 1'b0;
    wr_en     = 1'b0;
    rd_addr_a = '0;
    rd_addr_b = '0;
    tw_addr   = '0;
    wr_addr_a = '0;
    wr_addr_b = '0;
    busy      = (r_state == ST_PRIME) || (r_state == ST_RUN) || (r_state == ST_FLUSH);
    done      = (r_state == ST_DONE);
    rd_en     = (r_state == ST_PRIME) ||
                (r_state == ST_RUN && w_last_ph && r_j != J_LAST);
    bfly_strb = (r_state == ST_RUN || r_state == ST_FLUSH) && r_phase == PW'(0);
    // Slot 0 has no completed pair yet; FLUSH cycle 1 writes the last one.
    wr_en     = (r_state == ST_RUN && r_phase == PW'(1) && r_j != '0) ||
                (r_state == ST_FLUSH && r_phase == PW'(1));
    if (rd_en) begin
      rd_addr_a = w_rd_a;
      rd_addr_b = w_rd_b;
      tw_addr   = w_rd_tw;
    end
    if (wr_en) begin
      wr_addr_a = r_wa;
      wr_addr_b = r_wb;
    end
  end

endmodule
